// File: rtl/pipe_share_pkg.sv
// Shared types and width helpers for the pipe_share_arbiter slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Struct widths follow the PS_* defaults; the top-level parameter defaults come from the
// same constants, so override them together.
package pipe_share_pkg;

   localparam int PS_N_REQ      = 4;
   localparam int PS_DATA_W     = 32;
   localparam int PS_LATENCY    = 3;
   localparam int PS_FIFO_DEPTH = 4;

   // Requester ID width, at least one bit
   localparam int ID_W = (PS_N_REQ > 1) ? $clog2(PS_N_REQ) : 1;

   // Width of a counter that must reach n (inclusive)
   function automatic int cnt_width(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

   // One stage of the tag shift register running alongside the pipeline
   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

   // One captured pipeline result and its owning requester
   typedef struct packed {
      logic [ID_W-1:0]      id;
      logic [PS_DATA_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/pipe_share_result_fifo.sv
// Result FIFO holding {id, data} entries returned by the shared pipeline.
// Latency: a push into an empty FIFO is visible at head_o on the next cycle.
// Backpressure: a push when full is dropped unless a pop happens in the same cycle.
// Ports: push_i/push_dat_i write, pop_i removes the head, head_o/empty_o/full_o/count_o status.
module pipe_share_result_fifo
   import pipe_share_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  fifo_entry_t                  push_dat_i,
   input  logic                         pop_i,
   output fifo_entry_t                  head_o,
   output logic                         empty_o,
   output logic                         full_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              CW      = cnt_width(DEPTH);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0]   LAST_C  = PW'(DEPTH - 1);

   fifo_entry_t     mem_q [DEPTH];
   logic [PW-1:0]   wr_q;
   logic [PW-1:0]   rd_q;
   logic [CW-1:0]   count_q;
   logic            do_push;
   logic            do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DEPTH_C);
   assign do_pop  = pop_i && !empty_o;
   // Full plus simultaneous pop still frees a slot this cycle
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
            wr_q        <= (wr_q == LAST_C) ? '0 : wr_q + PW'(1);
         end
         if (do_pop) begin
            rd_q <= (rd_q == LAST_C) ? '0 : rd_q + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable pipeline among N_REQ requesters.
// Latency: grant is combinational; issue at cycle t gives resp_valid at t+LATENCY+1.
// Backpressure: credits (FIFO_DEPTH - fifo_count - inflight) gate issue; responses hold until resp_ready of the owner.
// Ports: req_* request channel, resp_* response channel (shared data bus), pipe_* pipeline
// side, inflight = issued-but-not-returned count, err = sticky protocol error.
module pipe_share_arbiter
   import pipe_share_pkg::*;
#(
   parameter int N_REQ      = PS_N_REQ,
   parameter int DATA_W     = PS_DATA_W,
   parameter int LATENCY    = PS_LATENCY,
   parameter int FIFO_DEPTH = PS_FIFO_DEPTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N_REQ-1:0]                   req_valid,
   input  logic [N_REQ*DATA_W-1:0]            req_data,
   output logic [N_REQ-1:0]                   req_ready,
   output logic [N_REQ-1:0]                   resp_valid,
   output logic [DATA_W-1:0]                  resp_data,
   input  logic [N_REQ-1:0]                   resp_ready,
   output logic                               pipe_in_valid,
   output logic [DATA_W-1:0]                  pipe_x,
   input  logic [DATA_W-1:0]                  pipe_out,
   input  logic                               pipe_out_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    inflight,
   output logic                               err
);

   localparam int              CW      = cnt_width(FIFO_DEPTH);
   localparam int              DW      = cnt_width(LATENCY);
   localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [DW-1:0]   LAT_C   = DW'(LATENCY);

   // Registered state
   logic [DW-1:0]     drain_q;
   logic [ID_W-1:0]   ptr_q;
   tag_t              tag_q [LATENCY];
   logic [CW-1:0]     inflight_q;
   logic [CW-1:0]     inflight_d;
   logic              err_q;
   logic              err_d;

   // Combinational
   logic [ID_W-1:0]   cand;
   logic [ID_W-1:0]   grant;
   logic              grant_vld;
   logic              live;
   logic              credit_ok;
   logic              issue;
   logic [CW:0]       used;
   tag_t              tag_in;
   tag_t              tail;
   logic              ret;
   logic              push;
   logic              pop;
   fifo_entry_t       push_dat;
   fifo_entry_t       head;
   logic              fifo_empty;
   logic              fifo_full;
   logic [CW-1:0]     fifo_count;

   // Round-robin: first valid requester searching upward from ptr+1 with wrap
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((int'(ptr_q) + k) % N_REQ);
         if (!grant_vld && req_valid[cand]) begin
            grant_vld = 1'b1;
            grant     = cand;
         end
      end
   end

   // Every FIFO slot is reserved at issue time, so a return can never find the FIFO full
   assign used      = {1'b0, fifo_count} + {1'b0, inflight_q};
   assign credit_ok = (used < DEPTH_C);
   // drain_q covers the pipeline's own flush after reset; its outputs are ignored meanwhile
   assign live      = (drain_q == '0);
   assign issue     = live && credit_ok && grant_vld;

   assign req_ready     = issue ? (N_REQ'(1) << grant) : '0;
   assign pipe_in_valid = issue;
   assign pipe_x        = issue ? req_data[int'(grant)*DATA_W +: DATA_W] : '0;

   always_comb begin
      tag_in     = '0;
      tag_in.vld = issue;
      tag_in.id  = issue ? grant : '0;
   end

   // Return side: the tail tag says who owns the result leaving the pipeline now
   assign tail = tag_q[LATENCY-1];
   // An operation leaves the credit pool when its tag retires, even if the data never
   // showed up, so a latency fault raises err without leaking credits forever
   assign ret  = live && tail.vld;
   assign push = ret && pipe_out_valid;

   always_comb begin
      push_dat      = '0;
      push_dat.id   = tail.id;
      push_dat.data = pipe_out;
   end

   pipe_share_result_fifo #(
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .head_o     (head),
      .empty_o    (fifo_empty),
      .full_o     (fifo_full),
      .count_o    (fifo_count)
   );

   // Head-of-line blocking across requesters is deliberate: strict issue order on return
   assign pop        = !fifo_empty && resp_ready[head.id];
   assign resp_valid = fifo_empty ? '0 : (N_REQ'(1) << head.id);
   assign resp_data  = fifo_empty ? '0 : head.data;

   always_comb begin
      err_d = err_q;
      // Data without a tag, or a tag without data
      if (live && (pipe_out_valid != tail.vld)) begin
         err_d = 1'b1;
      end
      if (push && fifo_full && !pop) begin
         err_d = 1'b1;
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      if (issue && !ret) begin
         inflight_d = inflight_q + CW'(1);
      end else if (!issue && ret) begin
         inflight_d = inflight_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_q    <= LAT_C;
         ptr_q      <= ID_W'(N_REQ - 1);
         inflight_q <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         if (!live) begin
            drain_q <= drain_q - DW'(1);
         end
         if (issue) begin
            ptr_q <= grant;
         end
         inflight_q <= inflight_d;
         err_q      <= err_d;
         tag_q[0]   <= tag_in;
         for (int i = 1; i < LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign inflight = inflight_q;
   assign err      = err_q;

endmodule

// File: tb/tb_pipe_share_arbiter.sv
module tb_pipe_share_arbiter;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [3:0]    req_valid = '0;
   logic [127:0]  req_data = '0;
   logic [3:0]    req_ready;
   logic [3:0]    resp_valid;
   logic [31:0]   resp_data;
   logic [3:0]    resp_ready = '0;
   logic          pipe_in_valid;
   logic [31:0]   pipe_x;
   logic [31:0]   pipe_out;
   logic          pipe_out_valid;
   logic [2:0]    inflight;
   logic          err;
   logic          spur = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [31:0] rr_dat [8] = '{32'h0000_0100, 32'h0000_0200, 32'hFFFF_FFFE, 32'h1234_5678,
                               32'hAAAA_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF};
   logic [31:0] rr_exp [8] = '{32'h0000_0103, 32'h0000_0203, 32'h0000_0001, 32'h1234_567B,
                               32'hAAAA_0003, 32'h8000_0002, 32'h0000_0004, 32'hDEAD_BEF2};

   always #5 clk = ~clk;

   // Pipeline model: three stages, result = x + 3; not reset so stale results flush out
   logic [2:0]  mv  = '0;
   logic [31:0] md0 = '0;
   logic [31:0] md1 = '0;
   logic [31:0] md2 = '0;
   always @(posedge clk) begin
      mv  <= {mv[1:0], pipe_in_valid};
      md0 <= pipe_x + 32'd3;
      md1 <= md0;
      md2 <= md1;
   end
   assign pipe_out_valid = mv[2] | spur;
   assign pipe_out       = md2;

   pipe_share_arbiter #(
      .N_REQ          (4),
      .DATA_W         (32),
      .LATENCY        (3),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .resp_ready     (resp_ready),
      .pipe_in_valid  (pipe_in_valid),
      .pipe_x         (pipe_x),
      .pipe_out       (pipe_out),
      .pipe_out_valid (pipe_out_valid),
      .inflight       (inflight),
      .err            (err)
   );

   // Leaves the caller two negedges after release; the next negedge is the first live cycle
   task automatic apply_reset();
      @(negedge clk);
      req_valid  = '0;
      resp_ready = '0;
      rst        = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      req_valid  = 4'hF;
      req_data   = {32'h4, 32'h3, 32'h2, 32'h1};
      resp_ready = 4'hF;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({req_ready, resp_valid, pipe_in_valid, inflight, err} !== 13'h0) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy=%b rv=%b piv=%b infl=%0d err=%b expected all zero",
                  req_ready, resp_valid, pipe_in_valid, inflight, err);
      end
      checks++;
      if ({pipe_x, resp_data} !== 64'h0) begin
         errors++;
         $display("FAIL reset_data: got pipe_x=%h resp_data=%h expected 0", pipe_x, resp_data);
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      rst        = 1'b0;
      req_valid  = 4'b0100;
      req_data   = '0;
      req_data[64 +: 32] = 32'h10;
      resp_ready = 4'hF;
      #1;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin
            @(negedge clk);
            #1;
         end
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_drain_block c=%0d: got %b expected 0000", c, req_ready);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0100 || pipe_in_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: got rdy=%b piv=%b expected 0100/1", req_ready, pipe_in_valid);
      end
      checks++;
      if (pipe_x !== 32'h10) begin
         errors++;
         $display("FAIL single_pipe_x: got %h expected 00000010", pipe_x);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = '0;
         #1;
         checks++;
         if (inflight !== 3'd1 || resp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL single_inflight c=%0d: got infl=%0d rv=%b expected 1/0000", c, inflight, resp_valid);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 4'b0100 || resp_data !== 32'h13) begin
         errors++;
         $display("FAIL single_resp: got rv=%b data=%h expected 0100/00000013", resp_valid, resp_data);
      end
      checks++;
      if (inflight !== 3'd0) begin
         errors++;
         $display("FAIL single_inflight_done: got %0d expected 0", inflight);
      end
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 4'b0000) begin
         errors++;
         $display("FAIL single_popped: got %b expected 0000", resp_valid);
      end
   endtask

   task automatic test_round_robin();
      int gcnt [4];
      int nissue;
      int nresp;
      nissue = 0;
      nresp  = 0;
      for (int i = 0; i < 4; i++) gcnt[i] = 0;
      apply_reset();
      resp_ready = 4'hF;
      for (int cyc = 0; cyc < 80 && nresp < 8; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (gcnt[i] < 2);
            req_data[i*32 +: 32] = (gcnt[i] < 2) ? rr_dat[gcnt[i]*4 + i] : 32'h0;
         end
         #1;
         if (req_ready != 4'b0000 && nissue < 8) begin
            checks++;
            if (req_ready !== (4'b0001 << (nissue % 4))) begin
               errors++;
               $display("FAIL rr_grant n=%0d: got %b expected %b", nissue, req_ready, 4'b0001 << (nissue % 4));
            end
            checks++;
            if (pipe_x !== rr_dat[nissue]) begin
               errors++;
               $display("FAIL rr_pipe_x n=%0d: got %h expected %h", nissue, pipe_x, rr_dat[nissue]);
            end
            gcnt[nissue % 4]++;
            nissue++;
         end
         if (resp_valid != 4'b0000 && nresp < 8) begin
            checks++;
            if (resp_valid !== (4'b0001 << (nresp % 4)) || resp_data !== rr_exp[nresp]) begin
               errors++;
               $display("FAIL rr_resp n=%0d: got rv=%b data=%h expected %b/%h", nresp, resp_valid,
                        resp_data, 4'b0001 << (nresp % 4), rr_exp[nresp]);
            end
            nresp++;
         end
      end
      checks++;
      if (nissue != 8 || nresp != 8) begin
         errors++;
         $display("FAIL rr_count: got issues=%0d responses=%0d expected 8/8", nissue, nresp);
      end
      req_valid = '0;
   endtask

   task automatic test_credit_limit();
      int nissue;
      nissue = 0;
      @(negedge clk);
      resp_ready = '0;
      req_valid  = 4'hF;
      req_data   = {32'h1000, 32'h1000, 32'h1000, 32'h1000};
      req_data[32 +: 32] = 32'h1001;
      req_data[64 +: 32] = 32'h1002;
      req_data[96 +: 32] = 32'h1003;
      #1;
      if (req_ready != 4'b0000) nissue++;
      for (int cyc = 0; cyc < 11; cyc++) begin
         @(negedge clk);
         #1;
         if (req_ready != 4'b0000) nissue++;
      end
      checks++;
      if (nissue != 4) begin
         errors++;
         $display("FAIL credit_issue_count: got %0d expected 4", nissue);
      end
      checks++;
      if (inflight !== 3'd0 || resp_valid !== 4'b0001 || resp_data !== 32'h1003) begin
         errors++;
         $display("FAIL credit_full_head: got infl=%0d rv=%b data=%h expected 0/0001/00001003",
                  inflight, resp_valid, resp_data);
      end
      @(negedge clk);
      resp_ready = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL credit_before_pop: got %b expected 0000", req_ready);
      end
      @(negedge clk);
      resp_ready = '0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL credit_after_pop: got %b expected 0001", req_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL credit_one_only: got %b expected 0000", req_ready);
      end
   endtask

   task automatic test_head_of_line();
      int nresp;
      nresp = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid  = '0;
         resp_ready = 4'b1000;
         #1;
         checks++;
         if (resp_valid !== 4'b0010 || resp_data !== 32'h1004) begin
            errors++;
            $display("FAIL hol_block c=%0d: got rv=%b data=%h expected 0010/00001004", c, resp_valid, resp_data);
         end
      end
      for (int cyc = 0; cyc < 30 && nresp < 4; cyc++) begin
         @(negedge clk);
         resp_ready = 4'hF;
         #1;
         if (resp_valid != 4'b0000) nresp++;
      end
      checks++;
      if (nresp != 4) begin
         errors++;
         $display("FAIL hol_drain_count: got %0d expected 4", nresp);
      end
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 4'b0000 || inflight !== 3'd0 || err !== 1'b0) begin
         errors++;
         $display("FAIL hol_idle: got rv=%b infl=%0d err=%b expected 0000/0/0", resp_valid, inflight, err);
      end
   endtask

   task automatic test_spurious();
      @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      #1;
      checks++;
      if (err !== 1'b1 || resp_valid !== 4'b0000 || inflight !== 3'd0) begin
         errors++;
         $display("FAIL spurious_err: got err=%b rv=%b infl=%0d expected 1/0000/0", err, resp_valid, inflight);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (err !== 1'b1 || resp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL spurious_sticky c=%0d: got err=%b rv=%b expected 1/0000", c, err, resp_valid);
         end
      end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      req_valid  = 4'b0001;
      req_data[0 +: 32] = 32'h500;
      resp_ready = 4'hF;
      #1;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin
            @(negedge clk);
            #1;
         end
         checks++;
         if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midop_issue c=%0d: got %b expected 0001", c, req_ready);
         end
      end
      @(negedge clk);
      checks++;
      if (inflight !== 3'd3) begin
         errors++;
         $display("FAIL midop_inflight: got %0d expected 3", inflight);
      end
      rst       = 1'b1;
      req_valid = 4'hF;
      #1;
      checks++;
      if ({req_ready, resp_valid, pipe_in_valid, inflight, err} !== 13'h0 || {pipe_x, resp_data} !== 64'h0) begin
         errors++;
         $display("FAIL midop_reset_outputs: got rdy=%b rv=%b piv=%b infl=%0d err=%b x=%h rd=%h expected all zero",
                  req_ready, resp_valid, pipe_in_valid, inflight, err, pipe_x, resp_data);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin
            @(negedge clk);
            #1;
         end
         checks++;
         if (req_ready !== 4'b0000 || resp_valid !== 4'b0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL midop_drain c=%0d: got rdy=%b rv=%b err=%b expected 0000/0000/0", c, req_ready, resp_valid, err);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL midop_first_grant: got %b expected 0001", req_ready);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = '0;
         #1;
         checks++;
         if (resp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL midop_no_stale c=%0d: got %b expected 0000", c, resp_valid);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 4'b0001 || resp_data !== 32'h503 || err !== 1'b0) begin
         errors++;
         $display("FAIL midop_fresh_resp: got rv=%b data=%h err=%b expected 0001/00000503/0", resp_valid, resp_data, err);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_credit_limit();
      test_head_of_line();
      test_spurious();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within 100000 time units");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
